// File: rtl/vcmux_rr_pkg.sv
// vcmux_rr_pkg: shared defaults, enable constants and one-hot decode for vcmux_rr
package vcmux_rr_pkg;
  localparam int NVCH_D = 4;
  localparam int DATAW_D = 64;
  localparam int PORTW_D = 3;
  localparam int VCHW_D = 2;
  localparam int CREDITS_D = 4;
  localparam int MAX_VCH = 32;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  function automatic int oh2bin(input logic [MAX_VCH-1:0] oh);
    int b;
    b = 0;
    for (int i = 0; i < MAX_VCH; i++) if (oh[i]) b = b | i;
    return b;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant
);
  logic [W-1:0] idx;
  // scan downward so the surviving hit is the nearest requester from ptr
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (req[idx]) grant = N'(1) << idx;
    end
  end
endmodule

// File: rtl/vcmux_rr.sv
// vcmux_rr: round-robin VC output mux with packet locking; define VCMUX_CREDIT_EN for per-VC downstream credits
module vcmux_rr import vcmux_rr_pkg::*; #(
  parameter int NVCH = NVCH_D,
  parameter int DATAW = DATAW_D,
  parameter int PORTW = PORTW_D,
  parameter int VCHW = VCHW_D,
  parameter int CREDITS = CREDITS_D
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NVCH-1:0]       ovalid_i,
  input  logic [NVCH*DATAW-1:0] odata_i,
  input  logic [NVCH-1:0]       req_i,
  input  logic [NVCH*PORTW-1:0] port_i,
  input  logic [NVCH-1:0]       credit_ret,
  output logic [NVCH-1:0]       ordy_o,
  output logic                  ovalid,
  output logic [DATAW-1:0]      odata,
  output logic [VCHW-1:0]       ovch,
  output logic                  req,
  output logic [PORTW-1:0]      port,
  output logic [NVCH-1:0]       vcsel
);
  logic [NVCH-1:0] last, arb, nxt;
  logic [VCHW-1:0] rrptr;
  logic [DATAW-1:0] dv [NVCH];
  logic [PORTW-1:0] pv [NVCH];
  logic any, credit_ok, eligible;
  int nb;
  for (genvar v = 0; v < NVCH; v++) begin : g_split
    assign dv[v] = odata_i[v*DATAW +: DATAW];
    assign pv[v] = port_i[v*PORTW +: PORTW];
  end
  rr_arbiter #(.N(NVCH), .W(VCHW)) u_arb (.req(req_i), .ptr(rrptr), .grant(arb));
  assign req = |(last & req_i);
  assign nxt = req ? last : arb;
  assign nb = oh2bin(MAX_VCH'(nxt));
  // grant register; pointer moves past a VC only when it newly wins
  always_ff @(posedge clk or posedge rst_)
    if (rst_) begin
      last <= '0;
      rrptr <= '0;
    end else begin
      last <= nxt;
      if (|nxt && nxt != last) rrptr <= VCHW'(nb == NVCH - 1 ? 0 : nb + 1);
    end
  assign any = |last;
  assign vcsel = last;
  assign ovch = VCHW'(oh2bin(MAX_VCH'(last)));
  assign odata = any ? dv[ovch] : '0;
  assign port = any ? pv[ovch] : '0;
  assign eligible = any & ovalid_i[ovch] & credit_ok;
  assign ovalid = eligible;
  assign ordy_o = eligible ? last : '0;
`ifdef VCMUX_CREDIT_EN
  localparam int CW = $clog2(CREDITS + 1);
  logic [CW-1:0] cnt [NVCH];
  assign credit_ok = (cnt[ovch] != '0) ? ENABLE : DISABLE;
  // per-VC credits: spend on an accepted flit, refill on return, saturating both ways
  always_ff @(posedge clk or posedge rst_)
    if (rst_) begin
      for (int v = 0; v < NVCH; v++) cnt[v] <= CW'(CREDITS);
    end else begin
      for (int v = 0; v < NVCH; v++)
        if (ordy_o[v] && !credit_ret[v] && cnt[v] != '0) cnt[v] <= cnt[v] - CW'(1);
        else if (credit_ret[v] && !ordy_o[v] && cnt[v] != CW'(CREDITS)) cnt[v] <= cnt[v] + CW'(1);
    end
`else
  logic unused_credit;
  assign credit_ok = ENABLE;
  assign unused_credit = ^{credit_ret, CREDITS[0]};
`endif
endmodule

// File: tb/tb_vcmux_rr.sv
// tb_vcmux_rr: table, directed and randomized model checks of vcmux_rr
module tb_vcmux_rr;
  localparam int N = 4, DW = 64, PW = 3, VW = 2, CR = 4;
  typedef struct {
    logic [N-1:0] rq;
    logic [N-1:0] vl;
    logic [N-1:0] sel;
    logic ov;
    logic [VW-1:0] ch;
    logic [DW-1:0] dat;
  } vec_t;
  logic clk = 1'b0, rst_ = 1'b1;
  logic [N-1:0] ovalid_i = '0, req_i = '0, credit_ret = '0;
  logic [N*DW-1:0] odata_i = '0;
  logic [N*PW-1:0] port_i = '0;
  logic [N-1:0] ordy_o, vcsel;
  logic ovalid, req;
  logic [DW-1:0] odata;
  logic [VW-1:0] ovch;
  logic [PW-1:0] port;
  int vectors = 0, miscompares = 0;
  int mg = -1, mptr = 0;
  int mcnt [N];
  int held [N];
  int exp_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  vec_t tbl [9];
  always #5 clk = ~clk;
  vcmux_rr #(.NVCH(N), .DATAW(DW), .PORTW(PW), .VCHW(VW), .CREDITS(CR)) dut (
    .clk(clk), .rst_(rst_), .ovalid_i(ovalid_i), .odata_i(odata_i), .req_i(req_i),
    .port_i(port_i), .credit_ret(credit_ret), .ordy_o(ordy_o), .ovalid(ovalid),
    .odata(odata), .ovch(ovch), .req(req), .port(port), .vcsel(vcsel)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b1;
    req_i = '0;
    ovalid_i = '0;
    credit_ret = '0;
    #1;
    chk("rst_vcsel", vcsel, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_odata", odata, 0);
    chk("rst_ovch", ovch, 0);
    chk("rst_req", req, 0);
    chk("rst_port", port, 0);
    chk("rst_ordy", ordy_o, 0);
    @(negedge clk);
    rst_ = 1'b0;
    mg = -1;
    mptr = 0;
    for (int v = 0; v < N; v++) mcnt[v] = CR;
  endtask
  function automatic bit m_ok();
    bit ok;
    ok = mg >= 0 && ovalid_i[mg];
`ifdef VCMUX_CREDIT_EN
    if (mg >= 0 && mcnt[mg] == 0) ok = 1'b0;
`endif
    return ok;
  endfunction
  task automatic check_model();
    logic [N-1:0] ev;
    ev = mg >= 0 ? N'(1) << mg : '0;
    chk("rnd_vcsel", vcsel, ev);
    chk("rnd_ovch", ovch, mg >= 0 ? mg : 0);
    chk("rnd_odata", odata, mg >= 0 ? odata_i[mg*DW +: DW] : 0);
    chk("rnd_port", port, mg >= 0 ? port_i[mg*PW +: PW] : 0);
    chk("rnd_req", req, mg >= 0 && req_i[mg]);
    chk("rnd_ovalid", ovalid, m_ok());
    chk("rnd_ordy", ordy_o, m_ok() ? ev : 0);
  endtask
  task automatic model_edge();
    int ng;
    bit acc;
    acc = m_ok();
    ng = -1;
    if (mg >= 0 && req_i[mg]) ng = mg;
    else for (int i = 0; i < N; i++) if (ng < 0 && req_i[(mptr + i) % N]) ng = (mptr + i) % N;
    if (ng >= 0 && ng != mg) mptr = (ng + 1) % N;
`ifdef VCMUX_CREDIT_EN
    for (int v = 0; v < N; v++) begin
      mcnt[v] += int'(credit_ret[v]) - ((acc && v == mg) ? 1 : 0);
      if (mcnt[v] > CR) mcnt[v] = CR;
    end
`else
    acc = 1'b0;
`endif
    mg = ng;
  endtask
  initial begin
    tbl[0] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 64'hA5};
    tbl[1] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 64'hA5};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 64'h0};
    tbl[3] = '{4'b0011, 4'b1111, 4'b0001, 1'b1, 2'd0, 64'h10};
    tbl[4] = '{4'b0011, 4'b0000, 4'b0001, 1'b0, 2'd0, 64'h10};
    tbl[5] = '{4'b0010, 4'b1111, 4'b0010, 1'b1, 2'd1, 64'h11};
    tbl[6] = '{4'b0011, 4'b1111, 4'b0010, 1'b1, 2'd1, 64'h11};
    tbl[7] = '{4'b0001, 4'b1111, 4'b0001, 1'b1, 2'd0, 64'h10};
    tbl[8] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 64'h0};
    odata_i = {64'h13, 64'hA5, 64'h11, 64'h10};
    port_i = {3'd4, 3'd3, 3'd2, 3'd1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req_i = tbl[i].rq;
      ovalid_i = tbl[i].vl;
      @(posedge clk);
      #1;
      chk("tbl_vcsel", vcsel, tbl[i].sel);
      chk("tbl_ovalid", ovalid, tbl[i].ov);
      chk("tbl_ovch", ovch, tbl[i].ch);
      chk("tbl_odata", odata, tbl[i].dat);
      chk("tbl_ordy", ordy_o, tbl[i].ov ? tbl[i].sel : 0);
      chk("tbl_req", req, |(tbl[i].rq & tbl[i].sel));
      chk("tbl_port", port, tbl[i].sel != 0 ? tbl[i].ch + 1 : 0);
    end
    do_reset();
    ovalid_i = '1;
    req_i = '1;
    for (int v = 0; v < N; v++) held[v] = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("rot_vcsel", vcsel, N'(1) << exp_seq[c]);
      chk("rot_ovalid", ovalid, 1);
      req_i = '1;
      for (int v = 0; v < N; v++)
        if (vcsel[v]) begin
          held[v]++;
          if (held[v] == 2) begin
            req_i[v] = 1'b0;
            held[v] = 0;
          end
        end
    end
    do_reset();
    req_i = 4'b0010;
    ovalid_i = 4'b0010;
    @(posedge clk);
    #1;
    chk("mr_grant", vcsel, 4'b0010);
    #3 rst_ = 1'b1;
    #1;
    chk("mr_vcsel", vcsel, 0);
    chk("mr_ovalid", ovalid, 0);
    chk("mr_odata", odata, 0);
    @(negedge clk);
    rst_ = 1'b0;
    req_i = '1;
    ovalid_i = '1;
    @(posedge clk);
    #1;
    chk("mr_regrant", vcsel, 4'b0001);
`ifdef VCMUX_CREDIT_EN
    do_reset();
    req_i = 4'b0001;
    ovalid_i = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("cr_ovalid", ovalid, c < 4);
      chk("cr_ordy", ordy_o, c < 4 ? 1 : 0);
      chk("cr_vcsel", vcsel, 1);
    end
    credit_ret = 4'b0001;
    @(posedge clk);
    #1;
    credit_ret = '0;
    chk("cr_ret_ovalid", ovalid, 1);
    chk("cr_ret_ordy", ordy_o, 1);
    @(posedge clk);
    #1;
    chk("cr_empty_again", ovalid, 0);
    ovalid_i = '0;
    credit_ret = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    ovalid_i = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1 chk("cr_same_ovalid", ovalid, 1);
      @(posedge clk);
      #1;
    end
    credit_ret = '0;
    #1 chk("cr_drain0", ovalid, 1);
    @(posedge clk);
    #1 chk("cr_drain1", ovalid, 1);
    @(posedge clk);
    #1 chk("cr_drain2", ovalid, 0);
`endif
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int v = 0; v < N; v++) begin
        if ($urandom_range(3) == 0) req_i[v] = ~req_i[v];
        credit_ret[v] = $urandom_range(3) == 0;
        odata_i[v*DW +: DW] = {$urandom, $urandom};
      end
      ovalid_i = N'($urandom);
      port_i = 12'($urandom);
      #1 check_model();
      @(posedge clk);
      model_edge();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vcmux_rr.md
Name: vcmux_rr

Overview:
- Parametrised N-virtual-channel output multiplexer for a router output port; successor to the single-VC vcmux.
- Arbitrates among NVCH VCs with round-robin fairness and packet-level locking: a granted VC holds the output until it drops req.
- Drives one selected VC's flit, VC id and port to the link.
- Optionally tracks downstream credits per VC and backpressures upstream.

Parameters:
- NVCH, 4, number of virtual channels (>=2).
- DATAW, 64, flit data width.
- PORTW, 3, output-port field width.
- VCHW, 2, VC index width (clog2(NVCH)).
- CREDITS, 4, downstream buffer depth per VC (credit feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_  in  1  reset, asynchronous, active-high (asserted when 1).
- ovalid_i  in  NVCH  per-VC flit valid.
- odata_i  in  NVCH*DATAW  per-VC flit data; VC v occupies bits [v*DATAW +: DATAW].
- req_i  in  NVCH  per-VC packet request; high from head through tail.
- port_i  in  NVCH*PORTW  per-VC destination port.
- credit_ret  in  NVCH  per-VC credit return pulse from downstream.
- ordy_o  out  NVCH  per-VC flit accepted this cycle.
- ovalid  out  1  output flit valid.
- odata  out  DATAW  output flit data.
- ovch  out  VCHW  binary index of the granted VC.
- req  out  1  OR of the granted VC's req.
- port  out  PORTW  granted VC's port.
- vcsel  out  NVCH  one-hot registered grant.

Behaviour:
- State:
  - last[NVCH-1:0]: registered one-hot grant, output as vcsel.
  - rrptr[VCHW-1:0]: round-robin priority pointer.
  - cnt[v]: credit counters, present only with the optional feature.
- Reset: last=0, rrptr=0, cnt[v]=CREDITS. All outputs read 0 (ovalid, odata, ovch, req, port, vcsel, ordy_o).
- Hold rule: if (last & req_i) != 0, the next grant equals last.
- Arbitration: otherwise the next grant is the first VC with req_i set, searching from rrptr upward with wrap (NVCH-1 -> 0). If no VC requests, the next grant is 0.
- last <= next grant every cycle.
- rrptr <= (granted index + 1) mod NVCH, only on a cycle where a new non-zero grant differs from last.
- Latency: a request seen at edge t is granted in last after edge t. Data path is driven from last in the following cycle, so there is one cycle from req to ovalid.
- Output mux, selected by last:
  - odata, ovch, port, req come from the selected VC; all 0 when last=0.
  - eligible = ovalid_i[sel] and (credit feature ? cnt[sel]>0 : 1).
  - ovalid = eligible.
  - ordy_o = last masked by eligible.
- Lock release: when the locked VC drops req_i, the hold clears in that same cycle and the new arbitration result lands next edge. No idle cycle is inserted if another VC requests.
- Simultaneous requests from all VCs: strict rotation, one packet each, in order from rrptr.
- Reset mid-packet: grant and pointer clear immediately (async) and credits restore. Upstream must restart its packet.
- vcsel is always zero or one-hot. ovch is the binary encoding of vcsel.

Optional Feature:
- Macro: VCMUX_CREDIT_EN.
- Defined:
  - Per-VC counter of width clog2(CREDITS+1).
  - Decrements on ovalid with ovch=v.
  - Increments on credit_ret[v].
  - Both in the same cycle: unchanged.
  - Saturates: never above CREDITS, never below 0.
  - A locked VC with cnt=0 keeps its lock but ovalid=0 and ordy_o=0 (stall).
- Not defined: no counters, credit_ret ignored, eligible=ovalid_i[sel].

Decomposition:
- Shared define/package holds: NVCH, DATAW, PORTW, VCHW, CREDITS defaults; Enable/Disable constants; one-hot-to-binary function.
- Sub-module rr_arbiter (req, pointer -> one-hot grant). It is reused by the router switch allocator.

Test Plan:
- Reset then single VC2 req+ovalid with data 0xA5 -> vcsel=0100 after 1 edge; ovalid=1, odata=0xA5, ovch=2 next cycle.
- All 4 VCs request, each drops req after 2 flits -> grant order 0,1,2,3,0, each held exactly 2 cycles; no idle gaps.
- VC1 locked while VC0 requests -> VC1 holds until its req falls, then VC0 granted on the next edge.
- Credit feature, CREDITS=4, VC0 sends 5 flits with no return -> 4 accepted, 5th has ovalid=0 and ordy_o[0]=0. One credit_ret[0] pulse -> 5th accepted next cycle.
- Credit_ret and send on the same cycle with cnt=2 -> cnt stays 2.
- rst_ asserted mid-packet -> vcsel, ovalid, odata = 0 immediately; after release, VC0 request is granted first (rrptr=0).
